// File: rtl/counter_ctrl.sv
// Button front-end for the 5-bit counter: synchronise, debounce and edge-detect three buttons,
// generate the step tick and sequence run/pause/load/mode onto the counter control inputs.
module counter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned TICK_DIV        = 25000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_set,
  input  logic i_btn_pause,
  input  logic i_btn_mode,
  output logic o_set,
  output logic o_pause,
  output logic o_count,
  output logic o_tick,
  output logic o_paused
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam logic [DbW-1:0]   DbMax   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  localparam int unsigned BtnSet   = 0;
  localparam int unsigned BtnPause = 1;
  localparam int unsigned BtnMode  = 2;

  typedef enum logic [1:0] {StRun, StPaused, StLoad} state_e;

  logic [2:0]       btn_raw;
  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       stable_q, stable_d;
  logic [2:0]       prev_q;
  logic [2:0]       press;
  logic [DbW-1:0]   db_cnt_q [3];
  logic [DbW-1:0]   db_cnt_d [3];
  logic [TickW-1:0] presc_q, presc_d;
  logic             tick;
  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  logic             set_q, set_d;
  logic             pause_q, pause_d;
  logic             count_q, count_d;
  logic             tick_q, tick_d;
  logic             paused_q, paused_d;

  assign btn_raw = {i_btn_mode, i_btn_pause, i_btn_set};

  // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbMax) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  assign press = stable_q & ~prev_q;

  assign tick    = (presc_q == TickMax);
  assign presc_d = tick ? '0 : presc_q + TickW'(1);

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      StRun, StPaused: begin
        // Set wins over a pause press landing in the same cycle.
        if (press[BtnSet]) begin
          state_d = StLoad;
          ret_d   = state_q;
        end else if (press[BtnPause]) begin
          state_d = (state_q == StRun) ? StPaused : StRun;
        end
      end
      StLoad:  state_d = ret_q;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    set_d    = 1'b0;
    pause_d  = 1'b1;
    paused_d = 1'b0;
    tick_d   = tick;
    count_d  = count_q ^ press[BtnMode];
    case (state_q)
      StRun:    pause_d = ~tick;
      StPaused: paused_d = 1'b1;
      StLoad: begin
        // The counter gives pause priority over set, so pause must drop for the load.
        set_d    = 1'b1;
        pause_d  = 1'b0;
        paused_d = (ret_q == StPaused);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      presc_q  <= '0;
      state_q  <= StRun;
      ret_q    <= StRun;
      set_q    <= 1'b0;
      pause_q  <= 1'b1;
      count_q  <= 1'b1;
      tick_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      presc_q  <= presc_d;
      state_q  <= state_d;
      ret_q    <= ret_d;
      set_q    <= set_d;
      pause_q  <= pause_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
      paused_q <= paused_d;
    end
  end

  assign o_set    = set_q;
  assign o_pause  = pause_q;
  assign o_count  = count_q;
  assign o_tick   = tick_q;
  assign o_paused = paused_q;

endmodule
